placement_reader: RTL and testbench
===================================

# placement_reader

Read-back engine on the far side of the placement flow. After the placer has written node coordinates into the pos_X/pos_Y RAMs and node IDs into the grid RAM, this block walks every node, reads its coordinates, optionally cross-checks the grid cell, and streams one record per node over a valid/ready interface. The stream feeds result dumping and external cost evaluation.

## Interface
Parameters:
- N_NODES, 7: number of node entries in the position RAMs (node IDs 0..N_NODES-1).
- GRID_N, 11: grid side length; grid address = x*GRID_N + y.
- DW, 32: data/address width, signed.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to begin a read-back pass; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the pass completes.
- pos_re  out  1  position RAM read enable (drives both X and Y RAMs).
- pos_addr  out  DW  node ID being read.
- pos_x_data  in  DW  X RAM dataRead; valid the cycle after pos_re.
- pos_y_data  in  DW  Y RAM dataRead; valid the cycle after pos_re.
- grid_re  out  1  grid RAM read enable.
- grid_addr  out  DW  grid cell address.
- grid_data  in  DW  grid dataRead; valid the cycle after grid_re.
- out_valid  out  1  record valid.
- out_ready  in  1  consumer accepts the record.
- out_node  out  DW  node ID.
- out_x, out_y  out  DW  coordinates as read (-1 if unplaced).
- out_status  out  2  0 OK, 1 UNPLACED, 2 OUT_OF_RANGE, 3 GRID_MISMATCH.
- err_count  out  DW  number of records with status 2 or 3 in the current pass.
- unplaced_count  out  DW  number of records with status 1 in the current pass.

## Operation
- States: IDLE, RD_POS, WAIT_POS, RD_GRID, WAIT_GRID, EMIT, DONE.
- IDLE: with start high, clear idx, err_count and unplaced_count, set busy, go to RD_POS.
- RD_POS: pos_re=1, pos_addr=idx, then WAIT_POS.
- WAIT_POS: latch x=pos_x_data, y=pos_y_data.
  - If x == -1 or y == -1: status UNPLACED, go to EMIT.
  - Else if x or y is outside [0, GRID_N-1]: status OUT_OF_RANGE, go to EMIT.
  - Else: grid_addr = x*GRID_N + y (signed DW arithmetic, truncated to DW), go to RD_GRID.
- RD_GRID: grid_re=1, then WAIT_GRID.
- WAIT_GRID: if grid_data == idx the status is OK, otherwise GRID_MISMATCH; go to EMIT.
- EMIT: out_valid=1 with the record held stable. On out_valid && out_ready, update the counters for that record.
  - If idx == N_NODES-1, go to DONE.
  - Otherwise increment idx and go to RD_POS.
- DONE: done=1 for one cycle, busy=0, go to IDLE. Counters hold their values until the next start.
- Read enables are high for exactly one cycle per access. The addresses hold their last values.

## Timing
- Reset values: busy=0, done=0, pos_re=0, pos_addr=0, grid_re=0, grid_addr=0, out_valid=0, out_node=0, out_x=0, out_y=0, out_status=0, err_count=0, unplaced_count=0. The state goes to IDLE.
- Cycles per node with out_ready held high:
  - 5 (RD_POS, WAIT_POS, RD_GRID, WAIT_GRID, EMIT) when the grid is read.
  - 3 when the grid is skipped (UNPLACED, OUT_OF_RANGE, or check compiled out).
- Latency:
  - start to first pos_re: 1 cycle.
  - Final handshake to done pulse: 1 cycle.
- Backpressure: EMIT holds indefinitely. The record must not change while out_valid=1 && !out_ready.
- start while busy is ignored. start in the same cycle as done is ignored; the pass returns to IDLE first.
- reset mid-pass: in the next cycle, all outputs are at their reset values and the state is IDLE. The in-flight record is dropped.
- N_NODES=1: one record, then done.

## Configuration
- PLACEMENT_READER_CHECK_EN defined:
  - Grid cross-check is compiled in, as described above.
- PLACEMENT_READER_CHECK_EN undefined:
  - RD_GRID and WAIT_GRID are removed. grid_re and grid_addr are tied to 0.
  - Placed in-range nodes go from WAIT_POS straight to EMIT with status OK.
  - GRID_MISMATCH is never produced. UNPLACED and OUT_OF_RANGE still are.

## Test plan
- All placed and consistent: N_NODES=7, node k at (k, 2k mod 11), grid holding matching IDs, out_ready=1. Expect 7 records with status 0, err_count=0, done 36 cycles after start (5 per node plus 1).
- Node 3 pos=(-1,-1): expect record 3 with status 1, no grid_re during node 3, unplaced_count=1.
- Node 2 at (4,5) while grid[49]=6: expect status 3, grid_addr=49, err_count=1.
- Node 5 pos=(11,0): expect status 2, no grid read, err_count=1.
- Backpressure: out_ready low for 4 cycles on record 0. Expect out_valid held with the record stable, then the handshake completes and record 1 follows. Also pulse start while busy and expect it ignored.
- Reset asserted during WAIT_GRID of node 4: expect all outputs at reset values the next cycle. A new start then produces records beginning at node 0.

Source files
------------

// File: rtl/placement_reader.sv
// Walks every node, reads its placed coordinates and streams one status record per node.
// Optional grid cross-check is compiled in with PLACEMENT_READER_CHECK_EN.
module placement_reader #(
   parameter int N_NODES = 7,
   parameter int GRID_N  = 11,
   parameter int DW      = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          pos_re,
   output logic [DW-1:0] pos_addr,
   input  logic [DW-1:0] pos_x_data,
   input  logic [DW-1:0] pos_y_data,
   output logic          grid_re,
   output logic [DW-1:0] grid_addr,
   input  logic [DW-1:0] grid_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_node,
   output logic [DW-1:0] out_x,
   output logic [DW-1:0] out_y,
   output logic [1:0]    out_status,
   output logic [DW-1:0] err_count,
   output logic [DW-1:0] unplaced_count
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] RD_POS    = 3'd1;
   localparam logic [2:0] WAIT_POS  = 3'd2;
`ifdef PLACEMENT_READER_CHECK_EN
   localparam logic [2:0] RD_GRID   = 3'd3;
   localparam logic [2:0] WAIT_GRID = 3'd4;
`endif
   localparam logic [2:0] EMIT      = 3'd5;
   localparam logic [2:0] DONE      = 3'd6;

   localparam logic [1:0] ST_OK       = 2'd0;
   localparam logic [1:0] ST_UNPLACED = 2'd1;
   localparam logic [1:0] ST_RANGE    = 2'd2;
   localparam logic [1:0] ST_MISMATCH = 2'd3;

   logic [2:0]    state;
   logic [DW-1:0] idx;
   logic          unplaced;
   logic          in_range;

   // Coordinates are signed; -1 marks an unplaced node, any other negative is out of range.
   assign unplaced = (pos_x_data == '1) || (pos_y_data == '1);
   assign in_range = !pos_x_data[DW-1] && (pos_x_data < DW'(GRID_N)) &&
                     !pos_y_data[DW-1] && (pos_y_data < DW'(GRID_N));

   assign busy      = (state != IDLE) && (state != DONE);
   assign done      = (state == DONE);
   assign pos_re    = (state == RD_POS);
   assign pos_addr  = idx;
   assign out_valid = (state == EMIT);

`ifdef PLACEMENT_READER_CHECK_EN
   logic [DW-1:0] grid_addr_q;
   logic [DW-1:0] cell_addr;

   // Low DW bits of the product are identical for signed and unsigned operands.
   assign cell_addr = pos_x_data * DW'(GRID_N) + pos_y_data;
   assign grid_re   = (state == RD_GRID);
   assign grid_addr = grid_addr_q;
`else
   logic unused_grid;

   assign unused_grid = ^grid_data;
   assign grid_re     = 1'b0;
   assign grid_addr   = '0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         idx            <= '0;
         out_node       <= '0;
         out_x          <= '0;
         out_y          <= '0;
         out_status     <= ST_OK;
         err_count      <= '0;
         unplaced_count <= '0;
`ifdef PLACEMENT_READER_CHECK_EN
         grid_addr_q    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  idx            <= '0;
                  err_count      <= '0;
                  unplaced_count <= '0;
                  state          <= RD_POS;
               end
            end
            RD_POS: state <= WAIT_POS;
            WAIT_POS: begin
               out_node <= idx;
               out_x    <= pos_x_data;
               out_y    <= pos_y_data;
               if (unplaced) begin
                  out_status <= ST_UNPLACED;
                  state      <= EMIT;
               end else if (!in_range) begin
                  out_status <= ST_RANGE;
                  state      <= EMIT;
               end else begin
`ifdef PLACEMENT_READER_CHECK_EN
                  grid_addr_q <= cell_addr;
                  state       <= RD_GRID;
`else
                  out_status  <= ST_OK;
                  state       <= EMIT;
`endif
               end
            end
`ifdef PLACEMENT_READER_CHECK_EN
            RD_GRID: state <= WAIT_GRID;
            WAIT_GRID: begin
               out_status <= (grid_data == idx) ? ST_OK : ST_MISMATCH;
               state      <= EMIT;
            end
`endif
            EMIT: begin
               if (out_ready) begin
                  if (out_status == ST_UNPLACED)
                     unplaced_count <= unplaced_count + DW'(1);
                  if (out_status[1])
                     err_count <= err_count + DW'(1);
                  if (idx == DW'(N_NODES - 1)) begin
                     state <= DONE;
                  end else begin
                     idx   <= idx + DW'(1);
                     state <= RD_POS;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_placement_reader.sv
// Directed bench for placement_reader: RAM models, per-scenario tasks, single summary line.
module tb_placement_reader;
   localparam int DW = 32;
   localparam int NN = 7;
   localparam int GN = 11;
`ifdef PLACEMENT_READER_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          busy, done, pos_re, grid_re, out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] pos_addr, grid_addr, out_node, out_x, out_y, err_count, unplaced_count;
   logic [DW-1:0] pos_x_data = '0;
   logic [DW-1:0] pos_y_data = '0;
   logic [DW-1:0] grid_data = '0;
   logic [1:0]    out_status;

   int vectors = 0;
   int miscompares = 0;

   logic [DW-1:0] mem_x [NN];
   logic [DW-1:0] mem_y [NN];
   logic [DW-1:0] mem_g [GN*GN];

   int            n_rec, done_cyc, first_pos, n_pos, stall_bad;
   logic [DW-1:0] rec_node [16];
   logic [DW-1:0] rec_x [16];
   logic [DW-1:0] rec_y [16];
   logic [1:0]    rec_st [16];
   logic [DW-1:0] rec_gaddr [16];
   int            gre_cnt [16];
   logic [1:0]    exp_st [NN];

   placement_reader #(.N_NODES(NN), .GRID_N(GN), .DW(DW)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .pos_re(pos_re), .pos_addr(pos_addr), .pos_x_data(pos_x_data), .pos_y_data(pos_y_data),
      .grid_re(grid_re), .grid_addr(grid_addr), .grid_data(grid_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_node(out_node),
      .out_x(out_x), .out_y(out_y), .out_status(out_status),
      .err_count(err_count), .unplaced_count(unplaced_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pos_re && pos_addr < NN) begin
         pos_x_data <= mem_x[int'(pos_addr)];
         pos_y_data <= mem_y[int'(pos_addr)];
      end
      if (grid_re && grid_addr < GN*GN)
         grid_data <= mem_g[int'(grid_addr)];
   end

   // Node k at (k, 2k mod 11); grid holds k at each of those cells, 99 elsewhere.
   task automatic load_base();
      for (int i = 0; i < GN*GN; i++) mem_g[i] = 99;
      for (int k = 0; k < NN; k++) begin
         mem_x[k] = k;
         mem_y[k] = (2*k) % GN;
         mem_g[k*GN + (2*k) % GN] = k;
         exp_st[k] = 2'd0;
      end
   endtask

   task automatic run_pass(input int stall_k, input int stall_n, input int extra_start_cyc);
      int cyc;
      int stall_left;
      logic [3*DW+1:0] snap;
      n_rec = 0; done_cyc = -1; first_pos = -1; n_pos = 0; stall_bad = 0;
      snap = '0;
      for (int i = 0; i < 16; i++) begin
         gre_cnt[i] = 0;
         rec_gaddr[i] = '0;
      end
      stall_left = stall_n;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 1;
      while (done_cyc < 0 && cyc < 400) begin
         start = (cyc == extra_start_cyc);
         if (pos_re) begin
            n_pos++;
            if (first_pos < 0) first_pos = cyc;
         end
         if (grid_re && n_rec < 16) begin
            gre_cnt[n_rec]++;
            rec_gaddr[n_rec] = grid_addr;
         end
         if (done) done_cyc = cyc;
         if (out_valid && stall_left > 0 && out_node == stall_k) begin
            if (stall_left == stall_n) snap = {out_node, out_x, out_y, out_status};
            else if (snap !== {out_node, out_x, out_y, out_status}) stall_bad++;
            out_ready = 1'b0;
            stall_left--;
         end else begin
            if (!out_valid && stall_left > 0 && stall_left < stall_n) stall_bad++;
            out_ready = 1'b1;
            if (out_valid && n_rec < 16) begin
               rec_node[n_rec] = out_node;
               rec_x[n_rec] = out_x;
               rec_y[n_rec] = out_y;
               rec_st[n_rec] = out_status;
               n_rec++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({busy, done, pos_re, grid_re, out_valid, out_status} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b want 0", {busy, done, pos_re, grid_re, out_valid, out_status});
      end
      vectors++;
      if ({pos_addr, grid_addr, out_node, out_x, out_y, err_count, unplaced_count} !== '0) begin
         miscompares++;
         $display("FAIL reset_data: got %h want 0",
                  {pos_addr, grid_addr, out_node, out_x, out_y, err_count, unplaced_count});
      end
      reset = 1'b0;
   endtask

   task automatic test_all_placed();
      load_base();
      run_pass(-1, 0, -1);
      vectors++;
      if (n_rec !== NN) begin miscompares++; $display("FAIL placed_count: got %0d want %0d", n_rec, NN); end
      vectors++;
      if (done_cyc !== (CHK ? 36 : 22)) begin
         miscompares++; $display("FAIL placed_done_cyc: got %0d want %0d", done_cyc, CHK ? 36 : 22);
      end
      vectors++;
      if (first_pos !== 1) begin miscompares++; $display("FAIL first_pos_re: got %0d want 1", first_pos); end
      vectors++;
      if (n_pos !== NN) begin miscompares++; $display("FAIL pos_re_count: got %0d want %0d", n_pos, NN); end
      for (int k = 0; k < NN; k++) begin
         vectors++;
         if ({rec_node[k], rec_x[k], rec_y[k], rec_st[k]} !== {DW'(k), mem_x[k], mem_y[k], 2'd0}) begin
            miscompares++;
            $display("FAIL placed_rec%0d: got node %0d (%0d,%0d) st %0d want node %0d (%0d,%0d) st 0",
                     k, rec_node[k], $signed(rec_x[k]), $signed(rec_y[k]), rec_st[k],
                     k, $signed(mem_x[k]), $signed(mem_y[k]));
         end
         vectors++;
         if (gre_cnt[k] !== (CHK ? 1 : 0)) begin
            miscompares++; $display("FAIL placed_grid_re%0d: got %0d want %0d", k, gre_cnt[k], CHK ? 1 : 0);
         end
      end
      vectors++;
      if (err_count !== 0 || unplaced_count !== 0) begin
         miscompares++; $display("FAIL placed_counters: got err %0d unpl %0d want 0 0", err_count, unplaced_count);
      end
      vectors++;
      if (grid_addr !== (CHK ? 67 : 0)) begin
         miscompares++; $display("FAIL placed_grid_addr: got %0d want %0d", grid_addr, CHK ? 67 : 0);
      end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_at_done: got %b want 0", busy); end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL done_one_cycle: got %b want 0", done); end
   endtask

   task automatic test_unplaced();
      load_base();
      mem_x[3] = '1; mem_y[3] = '1; exp_st[3] = 2'd1;
      run_pass(-1, 0, -1);
      vectors++;
      if (done_cyc !== (CHK ? 34 : 22)) begin
         miscompares++; $display("FAIL unpl_done_cyc: got %0d want %0d", done_cyc, CHK ? 34 : 22);
      end
      for (int k = 0; k < NN; k++) begin
         vectors++;
         if (rec_node[k] !== DW'(k) || rec_st[k] !== exp_st[k] ||
             gre_cnt[k] !== ((CHK && exp_st[k] == 0) ? 1 : 0)) begin
            miscompares++;
            $display("FAIL unpl_rec%0d: got node %0d st %0d grid_re %0d want node %0d st %0d",
                     k, rec_node[k], rec_st[k], gre_cnt[k], k, exp_st[k]);
         end
      end
      vectors++;
      if (rec_x[3] !== '1 || rec_y[3] !== '1) begin
         miscompares++; $display("FAIL unpl_xy: got (%0d,%0d) want (-1,-1)", $signed(rec_x[3]), $signed(rec_y[3]));
      end
      vectors++;
      if (unplaced_count !== 1 || err_count !== 0) begin
         miscompares++; $display("FAIL unpl_counters: got unpl %0d err %0d want 1 0", unplaced_count, err_count);
      end
   endtask

   task automatic test_mismatch();
      load_base();
      mem_x[2] = 4; mem_y[2] = 5; mem_g[49] = 6; exp_st[2] = CHK ? 2'd3 : 2'd0;
      run_pass(-1, 0, -1);
      vectors++;
      if (done_cyc !== (CHK ? 36 : 22)) begin
         miscompares++; $display("FAIL mism_done_cyc: got %0d want %0d", done_cyc, CHK ? 36 : 22);
      end
      for (int k = 0; k < NN; k++) begin
         vectors++;
         if (rec_node[k] !== DW'(k) || rec_st[k] !== exp_st[k]) begin
            miscompares++;
            $display("FAIL mism_rec%0d: got node %0d st %0d want node %0d st %0d", k, rec_node[k], rec_st[k], k, exp_st[k]);
         end
      end
      vectors++;
      if (rec_gaddr[2] !== (CHK ? 49 : 0)) begin
         miscompares++; $display("FAIL mism_grid_addr: got %0d want %0d", rec_gaddr[2], CHK ? 49 : 0);
      end
      vectors++;
      if (err_count !== (CHK ? 1 : 0) || unplaced_count !== 0) begin
         miscompares++;
         $display("FAIL mism_counters: got err %0d unpl %0d want %0d 0", err_count, unplaced_count, CHK ? 1 : 0);
      end
   endtask

   task automatic test_range();
      load_base();
      mem_x[4] = 10; mem_y[4] = 10; mem_g[120] = 4;
      mem_x[5] = 11; mem_y[5] = 0;  exp_st[5] = 2'd2;
      mem_x[6] = 0;  mem_y[6] = -5; exp_st[6] = 2'd2;
      run_pass(-1, 0, -1);
      vectors++;
      if (done_cyc !== (CHK ? 32 : 22)) begin
         miscompares++; $display("FAIL range_done_cyc: got %0d want %0d", done_cyc, CHK ? 32 : 22);
      end
      for (int k = 0; k < NN; k++) begin
         vectors++;
         if (rec_node[k] !== DW'(k) || rec_st[k] !== exp_st[k] ||
             gre_cnt[k] !== ((CHK && exp_st[k] == 0) ? 1 : 0)) begin
            miscompares++;
            $display("FAIL range_rec%0d: got node %0d st %0d grid_re %0d want node %0d st %0d",
                     k, rec_node[k], rec_st[k], gre_cnt[k], k, exp_st[k]);
         end
      end
      vectors++;
      if (err_count !== 2 || unplaced_count !== 0) begin
         miscompares++; $display("FAIL range_counters: got err %0d unpl %0d want 2 0", err_count, unplaced_count);
      end
   endtask

   task automatic test_backpressure();
      load_base();
      run_pass(0, 4, 3);
      vectors++;
      if (stall_bad !== 0) begin miscompares++; $display("FAIL bp_stable: got %0d changes want 0", stall_bad); end
      vectors++;
      if (n_rec !== NN || rec_node[0] !== 0 || rec_node[1] !== 1) begin
         miscompares++;
         $display("FAIL bp_records: got %0d recs first %0d,%0d want %0d recs 0,1", n_rec, rec_node[0], rec_node[1], NN);
      end
      vectors++;
      if (done_cyc !== (CHK ? 40 : 26)) begin
         miscompares++; $display("FAIL bp_done_cyc: got %0d want %0d", done_cyc, CHK ? 40 : 26);
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || pos_re !== 1'b0) begin
         miscompares++; $display("FAIL bp_idle_after: got busy %b pos_re %b want 0 0", busy, pos_re);
      end
   endtask

   task automatic test_reset_mid_pass();
      int cyc;
      int rst_cyc;
      load_base();
      mem_x[3] = '1; mem_y[3] = '1;
      rst_cyc = CHK ? 22 : 14;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 1;
      while (cyc < rst_cyc) begin
         @(negedge clk);
         cyc++;
      end
      vectors++;
      if (busy !== 1'b1 || pos_addr !== 4 || unplaced_count !== 1) begin
         miscompares++;
         $display("FAIL mid_pre_reset: got busy %b addr %0d unpl %0d want 1 4 1", busy, pos_addr, unplaced_count);
      end
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if ({busy, done, pos_re, grid_re, out_valid, out_status} !== 7'b0) begin
         miscompares++;
         $display("FAIL mid_reset_flags: got %b want 0", {busy, done, pos_re, grid_re, out_valid, out_status});
      end
      vectors++;
      if ({pos_addr, grid_addr, out_node, out_x, out_y, err_count, unplaced_count} !== '0) begin
         miscompares++;
         $display("FAIL mid_reset_data: got %h want 0",
                  {pos_addr, grid_addr, out_node, out_x, out_y, err_count, unplaced_count});
      end
      reset = 1'b0;
      run_pass(-1, 0, -1);
      vectors++;
      if (n_rec !== NN || rec_node[0] !== 0 || rec_st[3] !== 2'd1 || unplaced_count !== 1) begin
         miscompares++;
         $display("FAIL mid_restart: got %0d recs first %0d st3 %0d unpl %0d want %0d 0 1 1",
                  n_rec, rec_node[0], rec_st[3], unplaced_count, NN);
      end
      vectors++;
      if (done_cyc !== (CHK ? 34 : 22)) begin
         miscompares++; $display("FAIL mid_done_cyc: got %0d want %0d", done_cyc, CHK ? 34 : 22);
      end
   endtask

   initial begin
      load_base();
      test_reset();
      test_all_placed();
      test_unplaced();
      test_mismatch();
      test_range();
      test_backpressure();
      test_reset_mid_pass();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
